// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: sits between the hps_io ioctl download port and the core.
// It forwards download bytes to the ROM write port one cycle later with a
// one-hot region select, owns the core reset around downloads and refuses to
// release the core after a short or oversized image.
module rom_load_sequencer #(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] PROG_END    = 16'h4000,
  parameter logic [ADDR_W-1:0] BG_END      = 16'h5000,
  parameter logic [ADDR_W-1:0] FG_END      = 16'h6000,
  parameter logic [ADDR_W-1:0] TOTAL_BYTES = 16'h6200,
  parameter int                HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              ext_reset,
  output logic              core_reset,
  output logic              rom_wr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic [3:0]        rom_sel,
  output logic              dl_ok,
  output logic              dl_err
);

  localparam int                HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]     HOLD_LOAD = HW'(HOLD_CYCLES);
  // Full-width limit so any set upper ioctl address bit counts as out of range.
  localparam logic [24:0]       TOTAL_EXT = 25'(TOTAL_BYTES);

  typedef enum logic [2:0] {
    S_WAIT_ROM,
    S_LOADING,
    S_HOLD,
    S_RUN,
    S_FAULT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] byte_cnt;
  logic              overflow;
  logic [HW-1:0]     hold_cnt;

  logic              wr_accept;
  logic              wr_drop;
  logic [ADDR_W-1:0] addr_lo;
  logic [3:0]        sel_d;

  // Classify the incoming strobe: accepted into a region, or dropped as oversize.
  always_comb begin
    addr_lo   = dl_addr[ADDR_W-1:0];
    wr_accept = dl_active && dl_wr && (dl_addr < TOTAL_EXT);
    wr_drop   = dl_active && dl_wr && (dl_addr >= TOTAL_EXT);
    sel_d     = 4'b0000;
    if (wr_accept) begin
      if (addr_lo < PROG_END)    sel_d = 4'b0001;
      else if (addr_lo < BG_END) sel_d = 4'b0010;
      else if (addr_lo < FG_END) sel_d = 4'b0100;
      else                       sel_d = 4'b1000;
    end
  end

  // ROM write port: one cycle behind the ioctl strobe; select only with a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_wr   <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
      rom_sel  <= 4'b0000;
    end else begin
      rom_wr  <= wr_accept;
      rom_sel <= sel_d;
      if (wr_accept) begin
        rom_addr <= addr_lo;
        rom_data <= dl_data;
      end
    end
  end

  // Download / reset-release sequencer. A new download pre-empts every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_WAIT_ROM;
      byte_cnt <= '0;
      overflow <= 1'b0;
      hold_cnt <= '0;
      dl_ok    <= 1'b0;
      dl_err   <= 1'b0;
    end else if (dl_active && state != S_LOADING) begin
      // Counters restart here; a strobe on this very cycle is still counted so
      // the tally matches what the ROM port actually receives.
      state    <= S_LOADING;
      byte_cnt <= wr_accept ? ADDR_W'(1) : '0;
      overflow <= wr_drop;
      dl_ok    <= 1'b0;
      dl_err   <= 1'b0;
    end else begin
      unique case (state)
        S_LOADING: begin
          if (!dl_active) begin
            if (byte_cnt == TOTAL_BYTES && !overflow) begin
              state    <= S_HOLD;
              hold_cnt <= HOLD_LOAD;
              dl_ok    <= 1'b1;
              dl_err   <= 1'b0;
            end else begin
              state  <= S_FAULT;
              dl_ok  <= 1'b0;
              dl_err <= 1'b1;
            end
          end else begin
            if (wr_accept && byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
            if (wr_drop)                     overflow <= 1'b1;
          end
        end
        S_HOLD: begin
          if (ext_reset)           hold_cnt <= HOLD_LOAD;
          else if (hold_cnt == '0) state    <= S_RUN;
          else                     hold_cnt <= hold_cnt - 1'b1;
        end
        S_RUN: begin
          // Any external reset goes back through HOLD so release is stretched.
          if (ext_reset) begin
            state    <= S_HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        default: ;  // WAIT_ROM and FAULT wait for dl_active
      endcase
    end
  end

  // Only RUN lets the core go; there ext_reset passes straight through.
  assign core_reset = (state != S_RUN) || ext_reset;

endmodule
